// File: rtl/input_request_arbiter_pkg.sv
// input_request_arbiter_pkg: shared widths, FSM encodings and round-robin index helper
package input_request_arbiter_pkg;
  localparam int ISA_WIDTH = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  function automatic int rr_add(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction
endpackage

// File: rtl/input_request_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin one-hot selector
//   req : request vector, ptr : index searched first (wraps)
//   gnt : one-hot first request at/after ptr, idx : its index, 0 when none
module rr_priority_picker
  import input_request_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] ci;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    ci = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      ci = PW'(rr_add(int'(ptr), k, N));
      if (!found && req[ci]) begin
        gnt[ci] = 1'b1;
        idx = ci;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/input_request_arbiter.sv
// input_request_arbiter: round-robin sharing of the user input unit between requesters
//   req/grant/ack : per-requester level request, one-hot owner, one-cycle completion pulse
//   rdata         : captured input word (switches zero-extended or keypad), held after ack
//   busy          : transaction in progress, to hazard_unit
//   input_enable / input_complete / keypad_data / switch_data / switch_enable / cpu_pause : input_unit side
module input_request_arbiter
  import input_request_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SWITCH_WIDTH = 24,
  parameter int ARM_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      ack,
  output logic [ISA_WIDTH-1:0]    rdata,
  output logic                    busy,
  output logic                    input_enable,
  input  logic                    input_complete,
  input  logic [ISA_WIDTH-1:0]    keypad_data,
  input  logic [SWITCH_WIDTH-1:0] switch_data,
  input  logic                    switch_enable,
  input  logic                    cpu_pause
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ARM_TIMEOUT + 1);
  logic [1:0] state;
  logic [PW-1:0] rr_ptr, owner, pick_idx, next_ptr;
  logic [NUM_REQ-1:0] pick;
  logic [CW-1:0] cnt;
  assign next_ptr = PW'(rr_add(int'(owner), 1, NUM_REQ));
  rr_priority_picker #(.N(NUM_REQ)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .gnt(pick),
    .idx(pick_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      ack <= '0;
      rdata <= '0;
      busy <= 1'b0;
      input_enable <= 1'b0;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (!cpu_pause && |req) begin
          state <= ST_ARM;
          grant <= pick;
          owner <= pick_idx;
          busy <= 1'b1;
          input_enable <= 1'b1;
          cnt <= '0;
        end
        ST_ARM, ST_WAIT: if (!req[owner]) begin
          state <= ST_IDLE;
          grant <= '0;
          busy <= 1'b0;
          input_enable <= 1'b0;
          rr_ptr <= next_ptr;
          cnt <= '0;
        end else if (!cpu_pause) begin
          if (state == ST_WAIT) begin
            if (input_complete) begin
              state <= ST_DONE;
              ack <= grant;
              input_enable <= 1'b0;
              rdata <= switch_enable ? ISA_WIDTH'(switch_data) : keypad_data;
            end
          end else if (!input_complete) begin
            state <= ST_WAIT;
            input_enable <= 1'b1;
            cnt <= '0;
          end else if (!input_enable) begin
            // the one-cycle forced drop is over; counting restarts from zero
            input_enable <= 1'b1;
          end else if (cnt == CW'(ARM_TIMEOUT - 1)) begin
            // stale completion never cleared: pulse enable low to push input_unit back through BLOCK
            input_enable <= 1'b0;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          ack <= '0;
          busy <= 1'b0;
          rr_ptr <= next_ptr;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_request_arbiter.sv
// tb_input_request_arbiter: directed self-checking bench for input_request_arbiter
module tb_input_request_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req;
  logic [1:0] grant, ack;
  logic [31:0] rdata, keypad_data;
  logic busy, input_enable, input_complete, switch_enable, cpu_pause;
  logic [23:0] switch_data;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  input_request_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .ack(ack), .rdata(rdata),
    .busy(busy), .input_enable(input_enable), .input_complete(input_complete),
    .keypad_data(keypad_data), .switch_data(switch_data), .switch_enable(switch_enable),
    .cpu_pause(cpu_pause)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    input_complete = 1'b1;
    keypad_data = '0;
    switch_data = '0;
    switch_enable = 1'b0;
    cpu_pause = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic finish_txn(input logic [31:0] kd);
    input_complete = 1'b0;
    tick();
    input_complete = 1'b1;
    keypad_data = kd;
    tick();
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++; if ({grant, ack, busy, input_enable} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {grant, ack, busy, input_enable}); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
  endtask
  task automatic test_single();
    req = 2'b01;
    input_complete = 1'b1;
    tick();
    n_checks++; if ({grant, busy, input_enable} !== 4'b0111) begin n_fail++; $display("FAIL single_arm: got %b want 0111", {grant, busy, input_enable}); end
    input_complete = 1'b0;
    tick();
    n_checks++; if ({ack, input_enable} !== 3'b001) begin n_fail++; $display("FAIL single_wait: got %b want 001", {ack, input_enable}); end
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_noack_early: got %b want 00", ack); end
    input_complete = 1'b1;
    keypad_data = 32'd1234;
    tick();
    n_checks++; if ({ack, input_enable, busy} !== 4'b0101) begin n_fail++; $display("FAIL single_done: got %b want 0101", {ack, input_enable, busy}); end
    n_checks++; if (rdata !== 32'd1234) begin n_fail++; $display("FAIL single_rdata: got %0d want 1234", rdata); end
    req = 2'b00;
    tick();
    n_checks++; if ({grant, ack, busy} !== 5'b0) begin n_fail++; $display("FAIL single_idle: got %b want 00000", {grant, ack, busy}); end
  endtask
  task automatic test_round_robin();
    do_reset();
    req = 2'b11;
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rr_first: got %b want 01", grant); end
    finish_txn(32'h11);
    n_checks++; if (ack !== 2'b01 || rdata !== 32'h11) begin n_fail++; $display("FAIL rr_ack0: got %b/%h want 01/00000011", ack, rdata); end
    req = 2'b10;
    tick();
    n_checks++; if ({grant, ack} !== 4'b0) begin n_fail++; $display("FAIL rr_gap: got %b want 0000", {grant, ack}); end
    tick();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rr_second: got %b want 10", grant); end
    finish_txn(32'h22);
    n_checks++; if (ack !== 2'b10 || rdata !== 32'h22) begin n_fail++; $display("FAIL rr_ack1: got %b/%h want 10/00000022", ack, rdata); end
    req = 2'b00;
    tick();
    req = 2'b11;
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rr_wrap: got %b want 01", grant); end
    req = 2'b00;
    tick();
  endtask
  task automatic test_switch();
    req = 2'b01;
    switch_enable = 1'b1;
    switch_data = 24'hABCDEF;
    tick();
    finish_txn(32'hDEAD0000);
    n_checks++; if (ack !== 2'b01 || rdata !== 32'h00ABCDEF) begin n_fail++; $display("FAIL switch_rdata: got %b/%h want 01/00abcdef", ack, rdata); end
    req = 2'b00;
    switch_enable = 1'b0;
    tick();
  endtask
  task automatic test_abort();
    req = 2'b01;
    input_complete = 1'b1;
    tick();
    input_complete = 1'b0;
    tick();
    req = 2'b00;
    tick();
    n_checks++; if ({grant, ack, input_enable, busy} !== 6'b0) begin n_fail++; $display("FAIL abort_ctrl: got %b want 000000", {grant, ack, input_enable, busy}); end
    input_complete = 1'b1;
    tick();
    n_checks++; if (ack !== 2'b00 || rdata !== 32'h00ABCDEF) begin n_fail++; $display("FAIL abort_hold: got %b/%h want 00/00abcdef", ack, rdata); end
  endtask
  task automatic test_timeout();
    req = 2'b01;
    input_complete = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      n_checks++; if (input_enable !== 1'b1) begin n_fail++; $display("FAIL timeout_start%0d: got %b want 1", p, input_enable); end
      for (int i = 1; i < 15; i++) begin
        tick();
        n_checks++; if (input_enable !== 1'b1) begin n_fail++; $display("FAIL timeout_high%0d_%0d: got %b want 1", p, i, input_enable); end
      end
      tick();
      n_checks++; if (input_enable !== 1'b0 || grant !== 2'b01) begin n_fail++; $display("FAIL timeout_drop%0d: got %b/%b want 0/01", p, input_enable, grant); end
      tick();
    end
    n_checks++; if (input_enable !== 1'b1) begin n_fail++; $display("FAIL timeout_rearm: got %b want 1", input_enable); end
    req = 2'b00;
    tick();
  endtask
  task automatic test_pause_reset();
    cpu_pause = 1'b1;
    req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL pause_idle%0d: got %b want 00", i, grant); end
    end
    cpu_pause = 1'b0;
    tick();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL pause_release: got %b want 10", grant); end
    input_complete = 1'b0;
    tick();
    n_checks++; if ({busy, input_enable} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_wait: got %b want 11", {busy, input_enable}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({grant, ack, busy, input_enable} !== 6'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL async_reset: got %b/%h want 000000/00000000", {grant, ack, busy, input_enable}, rdata); end
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_switch();
    test_abort();
    test_timeout();
    test_pause_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/input_request_arbiter.md
Name: input_request_arbiter

Overview:
Shares the single user-input resource (keypad/switch input unit) between NUM_REQ requesters, e.g. the MEM-stage memory-mapped load and the system-call/debug unit. Grants one requester at a time, round-robin, then drives input_enable. Detects a fresh completion edge from the input unit, and returns the captured word with a one-cycle ack. Sits between data_mem/hazard_unit and input_unit.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
SWITCH_WIDTH, 24, width of raw switch word, zero-extended to ISA_WIDTH
ARM_TIMEOUT, 15, max cycles to wait for stale input_complete to clear before forcing re-arm

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester, held until ack
grant  out  NUM_REQ  one-hot current owner, 0 when idle
ack  out  NUM_REQ  one-cycle pulse to owner when rdata valid
rdata  out  ISA_WIDTH  captured input word, valid in ack cycle and held after
busy  out  1  to hazard_unit: an input transaction is in progress
input_enable  out  1  to input_unit
input_complete  in  1  from input_unit (level, stays high until next enable)
keypad_data  in  ISA_WIDTH  from input_unit
switch_data  in  SWITCH_WIDTH  hardware switches
switch_enable  in  1  from input_unit: switches selected
cpu_pause  in  1  from input_unit: user pause active

Behaviour:
- Reset (async, rst_n low): state IDLE; grant=0, ack=0, rdata=0, busy=0, input_enable=0, rr pointer=0, timeout counter=0.
- All state updates on posedge clk.
- States: IDLE, ARM, WAIT, DONE.
- IDLE:
  - if cpu_pause=1, stay IDLE; no new grant.
  - else if any req, grant the first requesting index at or after rr pointer (wrapping).
  - next cycle: ARM, grant one-hot, busy=1, input_enable=1.
- ARM: input_enable=1; wait for input_complete=0 (stale completion from the previous transaction cleared).
  - Transition to WAIT in the cycle after input_complete observed 0.
  - Counter increments each ARM cycle. At ARM_TIMEOUT: drop input_enable for one cycle, clear counter, stay in ARM (forces input_unit back through BLOCK).
- WAIT: input_enable=1; on input_complete=1, go to DONE.
  - Latch rdata = switch_enable ? zero-extended switch_data : keypad_data, sampled in that same cycle.
- DONE (exactly 1 cycle):
  - ack[owner]=1, input_enable=0, busy=0 at exit.
  - rr pointer = owner+1 mod NUM_REQ.
  - Next state IDLE; grant clears entering IDLE.
- Latency: minimum 3 cycles from grant to ack (ARM 1, WAIT 1, DONE); user-dependent otherwise.
- Abort: if req[owner] drops in ARM or WAIT, go to IDLE next cycle. input_enable=0, grant=0, no ack, rdata unchanged, rr pointer advanced.
- cpu_pause in ARM/WAIT: hold state and outputs; counter frozen.
- New req from a non-owner during a transaction: ignored until IDLE. No preemption.
- Simultaneous reqs in IDLE: rr pointer decides; pointer wraps NUM_REQ-1 -> 0.
- ack and grant never asserted for a requester whose req is low at grant time.
- Reset mid-transaction: immediate return to reset values. input_enable falls asynchronously.

Decomposition:
- Shared definitions package: ISA_WIDTH (existing), state encodings IDLE/ARM/WAIT/DONE (2-bit).
- One sub-module: rr_priority_picker (combinational round-robin one-hot selector from req and pointer), reusable by other arbiters.
- FSM, timeout counter and data latch stay in the top.

Test Plan:
- req=01, input_complete high from previous op, drops 1 cycle after enable, rises 5 cycles later with keypad_data=1234, switch_enable=0 -> grant=01, ack[0] pulse once, rdata=1234.
- req=11 simultaneously from reset -> requester 0 served first; after its ack, requester 1 granted; rr pointer then 0.
- switch_enable=1, switch_data=24'hABCDEF on completion -> rdata=32'h00ABCDEF.
- req[0] dropped in WAIT -> next cycle grant=0, input_enable=0, no ack, rdata retains prior value.
- input_complete stuck high for 15 ARM cycles -> input_enable low exactly one cycle, then re-asserted, counter restarted.
- cpu_pause=1 while IDLE with req=10 -> no grant until cpu_pause=0. rst_n low during WAIT -> all outputs 0 immediately.
